parity_frame_arbiter: RTL and testbench
=======================================

# parity_frame_arbiter

Shares one byte-wise parity engine between NUM_REQ requesters. Each requester streams a frame of bytes with a last marker. The block grants one requester at a time in round-robin order and accumulates the XOR parity of every bit in the frame. It then returns a single result word tagged with the requester index. It sits between the byte producers and the status/ECC logic that consumes per-frame parity.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, width of the result id; must satisfy 2^ID_W >= NUM_REQ
- TIMEOUT, 16, number of consecutive idle cycles from the granted requester mid-frame before the frame is aborted; 0 disables the timeout

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  8*NUM_REQ  per-requester byte; requester k uses bits [8k+7:8k]
- req_last  in  NUM_REQ  marks the final byte of a frame; qualified by valid
- req_ready  out  NUM_REQ  byte accept; combinational; high only for the granted requester while in STREAM
- grant  out  NUM_REQ  one-hot registered grant; all zero when not owned
- busy  out  1  high in STREAM and RESULT
- res_valid  out  1  result available
- res_ready  in  1  result consumed when high together with res_valid
- res_parity  out  1  XOR of all bits of all accepted bytes in the frame (1 = odd count of ones)
- res_id  out  ID_W  index of the requester that owned the frame
- res_count  out  8  number of accepted bytes; saturates at 255
- res_abort  out  1  frame terminated by timeout rather than by last

## Operation
- State machine with three states: IDLE, STREAM, RESULT.
- **IDLE**
  - If any req_valid is high, select the first set bit scanning upward from the pointer ptr, wrapping at NUM_REQ.
  - Next edge: load grant (one-hot), clear the parity accumulator, count and idle timer, then go to STREAM.
  - If no req_valid is high, stay in IDLE.
- **STREAM**
  - req_ready = grant. A beat is accepted when req_valid[g] and req_ready[g] are both high.
  - On each accepted beat: parity ^= reduction-XOR of the byte; count = min(count+1, 255); idle timer = 0.
  - On a cycle with no accepted beat: idle timer increments.
  - Accepted beat with req_last: go to RESULT with res_abort = 0. The final byte is included in the parity.
  - TIMEOUT != 0 and idle timer reaches TIMEOUT: go to RESULT with res_abort = 1, using the partial parity and count.
  - Valid, data and last from non-granted requesters are ignored; their req_ready stays 0.
- **RESULT**
  - res_valid = 1. res_parity, res_id, res_count and res_abort are held stable until the handshake.
  - On res_valid && res_ready: go to IDLE, clear grant, set ptr = (g+1) mod NUM_REQ.
  - res_ready while not in RESULT has no effect.
- A zero-byte frame is not possible: a frame always ends on an accepted beat or on a timeout. A timeout before any byte gives res_count = 0 and res_parity = 0.
- **Reset** (asynchronous, any time including mid-frame):
  - State goes to IDLE; ptr, grant, accumulator, count and timer go to 0.
  - Outputs: res_valid = 0, res_parity = 0, res_id = 0, res_count = 0, res_abort = 0, busy = 0, req_ready = 0.
  - Any partial frame is discarded with no result.

## Timing
- Arbitration latency: req_valid rising in IDLE at cycle N gives grant and req_ready at cycle N+1.
- A byte can be accepted every cycle in STREAM (full throughput).
- Last byte accepted at cycle M gives res_valid at cycle M+1.
- Minimum turnaround for a single-byte frame: request at N, accept at N+1, result at N+2. With res_ready already high, the block is back in IDLE at N+3 and the next grant appears at N+4.
- Timeout: the last accepted beat (or STREAM entry) is at cycle T; with valid low from then on, the idle timer reaches TIMEOUT and res_valid rises TIMEOUT+1 cycles later. Confirm exact edge alignment against the RTL counter definition.
- Round-robin applies only at IDLE → STREAM; a granted frame is never preempted.

## Test plan
- **Single-byte frames.** Requester 0 sends 8'hA5 with last → res_parity = 0, res_id = 0, res_count = 1, res_abort = 0. Then 8'h07 with last → res_parity = 1.
- **Multi-byte frame.** Requester 2 sends 8'h01, 8'h03, 8'h80 (last) with 1-cycle valid gaps → res_parity = 0, res_count = 3; the gaps change neither the result nor the abort flag.
- **Round-robin fairness.** All four req_valid held high, each frame one byte with last → grants in order 0,1,2,3,0. No requester is granted twice while another is waiting.
- **Backpressure.** res_ready held low for 5 cycles in RESULT → all res_* fields stable, req_ready all 0, no grant. res_ready then high → IDLE the next cycle.
- **Timeout.** TIMEOUT = 4; requester 1 sends 8'hFF then drops valid → res_abort = 1, res_count = 1, res_parity = 0, with res_valid rising per the timeout latency above.
- **Reset mid-frame.** rst pulsed after 2 bytes of a frame → outputs zero immediately, no result is produced, and the next request from requester 3 is granted first (ptr = 0, no other requests pending).

Source files
------------

// File: rtl/parity_frame_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter that shares one byte-wise parity engine between NUM_REQ
// frame producers and returns one tagged parity/count result per frame.
module parity_frame_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 res_parity,
  output logic [ID_W-1:0]      res_id,
  output logic [7:0]           res_count,
  output logic                 res_abort
);

  localparam int unsigned TimerW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {StIdle, StStream, StResult} state_e;

  state_e              state_q;
  logic [ID_W-1:0]     ptr_q;
  logic [ID_W-1:0]     id_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [TimerW-1:0]   timer_q;
  logic [7:0]          count_q;
  logic                parity_q;
  logic                abort_q;

  logic                sel_found;
  logic [ID_W-1:0]     sel_idx;
  logic [ID_W-1:0]     scan_idx;
  logic                beat_acc;
  logic                beat_last;
  logic [7:0]          beat_byte;

  // First valid requester at or above the pointer, wrapping at NUM_REQ.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    scan_idx  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_idx = ID_W'((32'(ptr_q) + i) % NUM_REQ);
      if (!sel_found && req_valid[scan_idx]) begin
        sel_found = 1'b1;
        sel_idx   = scan_idx;
      end
    end
  end

  assign req_ready = (state_q == StStream) ? grant_q : '0;
  assign beat_acc  = |(req_valid & req_ready);
  assign beat_last = req_last[id_q];
  assign beat_byte = req_data[{id_q, 3'b000} +: 8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      id_q     <= '0;
      grant_q  <= '0;
      timer_q  <= '0;
      count_q  <= '0;
      parity_q <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (sel_found) begin
            grant_q  <= NUM_REQ'(1) << sel_idx;
            id_q     <= sel_idx;
            timer_q  <= '0;
            count_q  <= '0;
            parity_q <= 1'b0;
            abort_q  <= 1'b0;
            state_q  <= StStream;
          end
        end
        StStream: begin
          if (beat_acc) begin
            parity_q <= parity_q ^ (^beat_byte);
            count_q  <= (count_q == 8'hFF) ? count_q : count_q + 8'd1;
            timer_q  <= '0;
            if (beat_last) state_q <= StResult;
          end else if (TIMEOUT != 0) begin
            // Abort on the idle cycle that brings the timer up to TIMEOUT.
            if (32'(timer_q) + 32'd1 == TIMEOUT) begin
              abort_q <= 1'b1;
              state_q <= StResult;
            end else begin
              timer_q <= timer_q + TimerW'(1);
            end
          end
        end
        StResult: begin
          if (res_ready) begin
            grant_q <= '0;
            ptr_q   <= ID_W'((32'(id_q) + 32'd1) % NUM_REQ);
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign grant      = grant_q;
  assign busy       = (state_q != StIdle);
  assign res_valid  = (state_q == StResult);
  assign res_parity = parity_q;
  assign res_id     = id_q;
  assign res_count  = count_q;
  assign res_abort  = abort_q;

endmodule

// File: tb/tb_parity_frame_arbiter.sv
`timescale 1ns/1ps
// Directed bench for parity_frame_arbiter: a frame-level reference model checked
// every cycle, plus literal expectations for each directed scenario.
module tb_parity_frame_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned TIMEOUT = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [8*NUM_REQ-1:0] req_data = '0;
  logic [NUM_REQ-1:0]   req_last = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   grant;
  logic                 busy;
  logic                 res_valid;
  logic                 res_ready = 1'b0;
  logic                 res_parity;
  logic [ID_W-1:0]      res_id;
  logic [7:0]           res_count;
  logic                 res_abort;

  int checks = 0;
  int errors = 0;

  parity_frame_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .grant     (grant),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_parity(res_parity),
    .res_id    (res_id),
    .res_count (res_count),
    .res_abort (res_abort)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the engine, which bytes the frame has collected,
  // and whether a finished frame is waiting to be handed over.
  int         m_owner     = -1;
  bit         m_in_result = 1'b0;
  bit         m_aborted   = 1'b0;
  bit         m_fresh     = 1'b1;
  int         m_next      = 0;
  int         m_idle      = 0;
  logic [7:0] m_frame[$];

  function automatic int m_ones();
    int s = 0;
    foreach (m_frame[i]) s += $countones(m_frame[i]);
    return s;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1; m_in_result = 0; m_aborted = 0; m_fresh = 1;
      m_next = 0; m_idle = 0; m_frame.delete();
    end else if (m_owner < 0) begin
      for (int k = 0; k < int'(NUM_REQ); k++) begin
        int c;
        c = (m_next + k) % int'(NUM_REQ);
        if (m_owner < 0 && req_valid[c]) begin
          m_owner = c; m_idle = 0; m_aborted = 0; m_fresh = 0; m_frame.delete();
        end
      end
    end else if (!m_in_result) begin
      if (req_valid[m_owner]) begin
        m_frame.push_back(req_data[8*m_owner +: 8]);
        m_idle = 0;
        if (req_last[m_owner]) m_in_result = 1;
      end else begin
        m_idle++;
        if (m_idle == int'(TIMEOUT)) begin
          m_in_result = 1; m_aborted = 1;
        end
      end
    end else if (res_ready) begin
      m_next = (m_owner + 1) % int'(NUM_REQ);
      m_owner = -1; m_in_result = 0;
    end
  end

  always @(negedge clk) begin
    logic [NUM_REQ-1:0] eg;
    logic [NUM_REQ-1:0] er;
    eg = (m_owner >= 0) ? (NUM_REQ'(1) << m_owner) : '0;
    er = (m_owner >= 0 && !m_in_result) ? eg : '0;
    check("busy", busy, m_owner >= 0);
    check("res_valid", res_valid, m_in_result);
    check("grant", grant, eg);
    check("req_ready", req_ready, er);
    if (m_in_result) begin
      check("m_parity", res_parity, m_ones() % 2);
      check("m_count", res_count, (m_frame.size() > 255) ? 255 : m_frame.size());
      check("m_id", res_id, m_owner);
      check("m_abort", res_abort, m_aborted);
    end else if (m_fresh) begin
      check("rst_parity", res_parity, 0);
      check("rst_count", res_count, 0);
      check("rst_id", res_id, 0);
      check("rst_abort", res_abort, 0);
    end
  end

  task automatic send_beat(int k, logic [7:0] d, bit last);
    int n = 0;
    req_valid[k] = 1'b1;
    req_data[8*k +: 8] = d;
    req_last[k] = last;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[k] && n < 50);
    check("beat_ready", req_ready[k], 1);
    @(posedge clk); #2;
    req_valid[k] = 1'b0;
    req_last[k] = 1'b0;
  endtask

  task automatic expect_result(string tag, bit par, int cnt, int id, bit ab, int hold);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!res_valid && n < 50);
    for (int c = 0; c <= hold; c++) begin
      if (c > 0) @(negedge clk);
      check({tag, "_valid"}, res_valid, 1);
      check({tag, "_parity"}, res_parity, par);
      check({tag, "_count"}, res_count, cnt);
      check({tag, "_id"}, res_id, id);
      check({tag, "_abort"}, res_abort, ab);
      if (hold > 0) check({tag, "_ready_low"}, req_ready, 0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_back_idle"}, busy, 0);
    #1 res_ready = 1'b0;
  endtask

  initial begin
    int n;
    int order[$];
    int exp_rr[5] = '{0, 1, 2, 3, 0};
    logic [NUM_REQ-1:0] prev;

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_count", res_count, 0);
    #1 rst = 1'b0;

    // Single-byte frames: A5 has four ones, 07 has three.
    send_beat(0, 8'hA5, 1);
    expect_result("a5", 0, 1, 0, 0, 0);
    @(posedge clk); #2;
    send_beat(0, 8'h07, 1);
    expect_result("07", 1, 1, 0, 0, 0);

    // Three bytes with one idle cycle between them.
    @(posedge clk); #2;
    send_beat(2, 8'h01, 0);
    @(posedge clk); #2;
    send_beat(2, 8'h03, 0);
    @(posedge clk); #2;
    send_beat(2, 8'h80, 1);
    expect_result("multi", 0, 3, 2, 0, 0);

    // Timeout: four idle edges after the accept edge, so res_valid shows in
    // the TIMEOUT+1'th cycle after the accepting cycle.
    @(posedge clk); #2;
    send_beat(1, 8'hFF, 0);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!res_valid && n < 20);
    check("timeout_latency", n, TIMEOUT);
    expect_result("timeout", 0, 1, 1, 1, 0);

    // Backpressure: result held for five cycles with res_ready low.
    @(posedge clk); #2;
    send_beat(3, 8'h3C, 1);
    expect_result("bp", 0, 1, 3, 0, 5);

    // Round robin with every requester asking continuously; pointer is 0 here.
    @(posedge clk); #2;
    req_data  = {8'h0F, 8'h07, 8'h03, 8'h01};
    req_last  = '1;
    res_ready = 1'b1;
    req_valid = '1;
    prev = '0;
    n = 0;
    while (order.size() < 5 && n < 100) begin
      @(posedge clk); #2;
      n++;
      if (grant != '0 && grant != prev) order.push_back($clog2(grant));
      prev = grant;
    end
    @(posedge clk); #2;
    req_valid = '0;
    req_last  = '0;
    repeat (2) @(posedge clk);
    #2 res_ready = 1'b0;
    check("rr_grants", order.size(), 5);
    foreach (order[i]) check($sformatf("rr_order%0d", i), order[i], exp_rr[i]);

    // Reset in the middle of a frame from requester 2.
    @(posedge clk); #2;
    send_beat(2, 8'h11, 0);
    send_beat(2, 8'h22, 0);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_grant", grant, 0);
    check("mid_rst_ready", req_ready, 0);
    check("mid_rst_count", res_count, 0);
    check("mid_rst_id", res_id, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("no_result_after_rst", res_valid, 0);
    send_beat(3, 8'h01, 1);
    expect_result("after_rst", 1, 1, 3, 0, 0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1);
  end

endmodule
